// File: rtl/regfile_op_sequencer.sv
// regfile_op_sequencer
// Drives one rd = rs1 OP rs2 operation through a 2-bit-serial register file.
// Each RUN cycle consumes the low 2 bits of both sources and writes a 2-bit
// result slice into the top of rd while every register rotates right by 2.
// After XLEN/2 cycles every register has made a full turn.
//
// Optional feature: define SEQ_IMM_EN to build the immediate shift register.
// When it is defined, req_use_imm selects req_imm as operand B. When it is
// undefined, operand B is always r_value2 and the immediate ports are ignored.
module regfile_op_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [3:0]      req_rd,
    input  logic [3:0]      req_rs1,
    input  logic [3:0]      req_rs2,
    input  logic            req_use_imm,
    input  logic [XLEN-1:0] req_imm,
    output logic [3:0]      r_sel1,
    output logic [3:0]      r_sel2,
    input  logic [1:0]      r_value1,
    input  logic [1:0]      r_value2,
    output logic [3:0]      write_register,
    output logic [1:0]      write_value,
    output logic            wr_en,
    output logic            shift,
    output logic            busy,
    output logic            done,
    output logic            carry_out,
    output logic            result_zero
);

    localparam int CNT_W = $clog2(XLEN / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN / 2 - 1);

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_PASSA = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [2:0]       op_reg;
    logic [3:0]       rd_reg;
    logic [3:0]       rs1_reg;
    logic [3:0]       rs2_reg;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             zero_acc;
    logic             ready_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             run_reg;

    logic             accept;
    logic             is_arith;
    logic [1:0]       operand_b;
    logic [2:0]       slice_res;

    // One 2-bit ALU slice; bit 2 of the result is the carry into the next slice.
    function automatic logic [2:0] alu_slice(input logic [2:0] op,
                                             input logic [1:0] a,
                                             input logic [1:0] b,
                                             input logic       cin);
        logic [2:0] r;
        case (op)
            OP_ADD:   r = {1'b0, a} + {1'b0, b} + {2'b00, cin};
            OP_SUB:   r = {1'b0, a} + {1'b0, ~b} + {2'b00, cin};
            OP_AND:   r = {1'b0, a & b};
            OP_OR:    r = {1'b0, a | b};
            OP_XOR:   r = {1'b0, a ^ b};
            OP_PASSA: r = {1'b0, a};
            default:  r = {1'b0, b};
        endcase
        return r;
    endfunction

    assign accept   = (state == IDLE) && req_valid;
    assign is_arith = (op_reg == OP_ADD) || (op_reg == OP_SUB);

`ifdef SEQ_IMM_EN
    logic [XLEN-1:0] imm_sr;
    logic            use_imm_reg;

    // Immediate is captured whole at acceptance and consumed 2 bits per RUN cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            imm_sr      <= req_imm;
            use_imm_reg <= req_use_imm;
        end else if (run_reg) begin
            imm_sr      <= imm_sr >> 2;
        end
    end

    assign operand_b = use_imm_reg ? imm_sr[1:0] : r_value2;
`else
    logic unused_imm;

    assign unused_imm = ^{req_use_imm, req_imm};
    assign operand_b  = r_value2;
`endif

    assign slice_res = alu_slice(op_reg, r_value1, operand_b, carry);

    // Sequencer FSM: accept, run XLEN/2 slices, pulse done, return to idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            run_reg   <= 1'b0;
            cnt       <= '0;
            carry     <= 1'b0;
            zero_acc  <= 1'b0;
            op_reg    <= '0;
            rd_reg    <= '0;
            rs1_reg   <= '0;
            rs2_reg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_reg    <= req_op;
                        rd_reg    <= req_rd;
                        rs1_reg   <= req_rs1;
                        rs2_reg   <= req_rs2;
                        cnt       <= '0;
                        // SUB is A + ~B + 1, so the serial carry starts at 1.
                        carry     <= (req_op == OP_SUB);
                        zero_acc  <= 1'b1;
                        ready_reg <= 1'b0;
                        busy_reg  <= 1'b1;
                        run_reg   <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (is_arith) begin
                        carry <= slice_res[2];
                    end
                    zero_acc <= zero_acc & (slice_res[1:0] == 2'b00);
                    cnt      <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        run_reg  <= 1'b0;
                        done_reg <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    ready_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    run_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready      = ready_reg;
    assign busy           = busy_reg;
    assign done           = done_reg;
    assign shift          = run_reg;
    assign wr_en          = run_reg;
    assign r_sel1         = rs1_reg;
    assign r_sel2         = rs2_reg;
    assign write_register = run_reg ? rd_reg : 4'd0;
    assign write_value    = run_reg ? slice_res[1:0] : 2'b00;
    assign carry_out      = carry;
    assign result_zero    = zero_acc;

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Directed bench for regfile_op_sequencer with a behavioural 2-bit-serial
// register file model attached to its file controls.
module tb_regfile_op_sequencer;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [3:0]      req_rd;
    logic [3:0]      req_rs1;
    logic [3:0]      req_rs2;
    logic            req_use_imm;
    logic [XLEN-1:0] req_imm;
    logic [3:0]      r_sel1;
    logic [3:0]      r_sel2;
    logic [1:0]      r_value1;
    logic [1:0]      r_value2;
    logic [3:0]      write_register;
    logic [1:0]      write_value;
    logic            wr_en;
    logic            shift;
    logic            busy;
    logic            done;
    logic            carry_out;
    logic            result_zero;

    int vectors = 0;
    int miscompares = 0;

    // Register file model: x0 hard zero, rotate right by 2 on shift,
    // the written slice enters at the top of the destination.
    logic [XLEN-1:0] rf [16] = '{default: '0};
    logic            load_en = 1'b0;
    logic [3:0]      load_idx = 4'd0;
    logic [XLEN-1:0] load_val = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load_en) begin
            if (load_idx != 4'd0) rf[load_idx] <= load_val;
        end else if (shift) begin
            for (int i = 1; i < 16; i++) begin
                if (wr_en && (write_register == 4'(i)))
                    rf[i] <= {write_value, rf[i][XLEN-1:2]};
                else
                    rf[i] <= {rf[i][1:0], rf[i][XLEN-1:2]};
            end
        end
    end

    assign r_value1 = rf[r_sel1][1:0];
    assign r_value2 = rf[r_sel2][1:0];

    regfile_op_sequencer #(.XLEN(XLEN)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_rd         (req_rd),
        .req_rs1        (req_rs1),
        .req_rs2        (req_rs2),
        .req_use_imm    (req_use_imm),
        .req_imm        (req_imm),
        .r_sel1         (r_sel1),
        .r_sel2         (r_sel2),
        .r_value1       (r_value1),
        .r_value2       (r_value2),
        .write_register (write_register),
        .write_value    (write_value),
        .wr_en          (wr_en),
        .shift          (shift),
        .busy           (busy),
        .done           (done),
        .carry_out      (carry_out),
        .result_zero    (result_zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [3:0] idx, input logic [XLEN-1:0] val);
        @(negedge clk);
        load_en  = 1'b1;
        load_idx = idx;
        load_val = val;
        @(negedge clk);
        load_en  = 1'b0;
    endtask

    // Issue one request, follow it to done, check timing and handshake.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [3:0] rd,
                         input logic [3:0] rs1, input logic [3:0] rs2,
                         input logic ui, input logic [XLEN-1:0] imm, input bit pulse);
        int n;
        int shifts;
        int ready_in_run;
        bit seen;
        @(negedge clk);
        chk({tag, "_ready_before"}, 32'(req_ready), 32'd1);
        req_valid   = 1'b1;
        req_op      = op;
        req_rd      = rd;
        req_rs1     = rs1;
        req_rs2     = rs2;
        req_use_imm = ui;
        req_imm     = imm;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        shifts = 0;
        ready_in_run = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (shift) shifts++;
                if (req_ready) ready_in_run++;
                if (pulse && n == 5) begin
                    req_valid = 1'b1;
                    req_op    = 3'b000;
                    req_rd    = 4'd9;
                end
                if (pulse && n == 7) req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        chk({tag, "_done_cycle"}, 32'(n), 32'd17);
        chk({tag, "_shift_cycles"}, 32'(shifts), 32'd16);
        chk({tag, "_ready_low_in_run"}, 32'(ready_in_run), 32'd0);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        chk({tag, "_ready_after"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_op      = 3'b000;
        req_rd      = 4'd0;
        req_rs1     = 4'd0;
        req_rs2     = 4'd0;
        req_use_imm = 1'b0;
        req_imm     = '0;

        // Reset held for 3 cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_shift", 32'(shift), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wreg", 32'(write_register), 32'd0);
        chk("rst_carry", 32'(carry_out), 32'd0);
        chk("rst_zero", 32'(result_zero), 32'd0);

        // ADD x1 = x0 + B, where B is imm=5 if built, else x5=5
`ifdef SEQ_IMM_EN
        preload(4'd5, 32'h0000_0077);
        do_op("add_imm", 3'b000, 4'd1, 4'd0, 4'd5, 1'b1, 32'h0000_0005, 1'b0);
`else
        preload(4'd5, 32'h0000_0005);
        do_op("add_imm", 3'b000, 4'd1, 4'd0, 4'd5, 1'b1, 32'hDEAD_0000, 1'b0);
`endif
        chk("add_imm_x1", rf[1], 32'h0000_0005);
        chk("add_imm_carry", 32'(carry_out), 32'd0);
        chk("add_imm_zero", 32'(result_zero), 32'd0);

        // ADD wrapping to zero
        preload(4'd1, 32'hFFFF_FFFF);
        preload(4'd2, 32'h0000_0001);
        do_op("add_wrap", 3'b000, 4'd3, 4'd1, 4'd2, 1'b0, '0, 1'b0);
        chk("add_wrap_x3", rf[3], 32'h0000_0000);
        chk("add_wrap_carry", 32'(carry_out), 32'd1);
        chk("add_wrap_zero", 32'(result_zero), 32'd1);
        chk("add_wrap_x1", rf[1], 32'hFFFF_FFFF);
        chk("add_wrap_x2", rf[2], 32'h0000_0001);

        // SUB with rd == rs1: 5 - 7
        preload(4'd1, 32'h0000_0005);
        preload(4'd2, 32'h0000_0007);
        do_op("sub_neg", 3'b001, 4'd1, 4'd1, 4'd2, 1'b0, '0, 1'b0);
        chk("sub_neg_x1", rf[1], 32'hFFFF_FFFE);
        chk("sub_neg_carry", 32'(carry_out), 32'd0);
        chk("sub_neg_x2", rf[2], 32'h0000_0007);

        // SUB 7 - 5
        preload(4'd1, 32'h0000_0005);
        do_op("sub_pos", 3'b001, 4'd5, 4'd2, 4'd1, 1'b0, '0, 1'b0);
        chk("sub_pos_x5", rf[5], 32'h0000_0002);
        chk("sub_pos_carry", 32'(carry_out), 32'd1);
        chk("sub_pos_zero", 32'(result_zero), 32'd0);

        // Logic ops; AND also gets a stray req_valid pulse during RUN
        preload(4'd1, 32'hF0F0_F0F0);
        preload(4'd2, 32'h0FF0_0FF0);
        do_op("and", 3'b010, 4'd4, 4'd1, 4'd2, 1'b0, '0, 1'b1);
        chk("and_x4", rf[4], 32'h00F0_00F0);
        chk("and_carry", 32'(carry_out), 32'd0);
        chk("and_idle_after", 32'(busy), 32'd0);
        chk("and_x9", rf[9], 32'h0000_0000);
        do_op("or", 3'b011, 4'd4, 4'd1, 4'd2, 1'b0, '0, 1'b0);
        chk("or_x4", rf[4], 32'hFFF0_FFF0);
        do_op("xor", 3'b100, 4'd4, 4'd1, 4'd2, 1'b0, '0, 1'b0);
        chk("xor_x4", rf[4], 32'hFF00_FF00);
        chk("xor_x1", rf[1], 32'hF0F0_F0F0);

        // PASSA / PASSB
        do_op("passa", 3'b101, 4'd7, 4'd1, 4'd2, 1'b0, '0, 1'b0);
        chk("passa_x7", rf[7], 32'hF0F0_F0F0);
        do_op("passb", 3'b111, 4'd7, 4'd1, 4'd2, 1'b0, '0, 1'b0);
        chk("passb_x7", rf[7], 32'h0FF0_0FF0);

        // Reset asserted at RUN cycle 8
        preload(4'd1, 32'h0000_0003);
        preload(4'd2, 32'h0000_0004);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 3'b000;
        req_rd    = 4'd6;
        req_rs1   = 4'd1;
        req_rs2   = 4'd2;
        req_use_imm = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort_in_run", 32'(shift), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_shift", 32'(shift), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
        end

        // Fresh ADD after reset
        preload(4'd1, 32'h0000_0003);
        preload(4'd2, 32'h0000_0004);
        do_op("add_post", 3'b000, 4'd6, 4'd1, 4'd2, 1'b0, '0, 1'b0);
        chk("add_post_x6", rf[6], 32'h0000_0007);
        chk("add_post_x2", rf[2], 32'h0000_0004);

        // rd == 0: file discards, flags still computed
        preload(4'd1, 32'hFFFF_FFFF);
        preload(4'd2, 32'h0000_0001);
        do_op("rd0", 3'b000, 4'd0, 4'd1, 4'd2, 1'b0, '0, 1'b0);
        chk("rd0_carry", 32'(carry_out), 32'd1);
        chk("rd0_zero", 32'(result_zero), 32'd1);
        chk("rd0_x1", rf[1], 32'hFFFF_FFFF);
        chk("rd0_x2", rf[2], 32'h0000_0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
